// File: rtl/ex_mem_elastic.sv
// EX/MEM elastic pipeline register: 2-entry main+skid store with registered in_ready,
// flush, and a forwarding lookup over both held entries.
module ex_mem_elastic #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_wd,
   input  logic              in_wreg,
   input  logic [DATA_W-1:0] in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_wd,
   output logic              out_wreg,
   output logic [DATA_W-1:0] out_wdata,
   input  logic [ADDR_W-1:0] fwd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic [1:0]        occupancy
);

   logic              main_valid_q, main_valid_d;
   logic [ADDR_W-1:0] main_wd_q, main_wd_d;
   logic              main_wreg_q, main_wreg_d;
   logic [DATA_W-1:0] main_wdata_q, main_wdata_d;
   logic              skid_valid_q, skid_valid_d;
   logic [ADDR_W-1:0] skid_wd_q, skid_wd_d;
   logic              skid_wreg_q, skid_wreg_d;
   logic [DATA_W-1:0] skid_wdata_q, skid_wdata_d;
   logic              in_fire_s, out_fire_s;
   logic              main_match_s, skid_match_s;

   // in_ready depends only on skid state (plus rst), never on out_ready
   assign in_ready   = !rst && !skid_valid_q;
   assign in_fire_s  = in_valid && in_ready;
   assign out_fire_s = main_valid_q && out_ready;

   // Next-state selection for the main/skid store
   always_comb begin
      main_valid_d = main_valid_q;
      main_wd_d    = main_wd_q;
      main_wreg_d  = main_wreg_q;
      main_wdata_d = main_wdata_q;
      skid_valid_d = skid_valid_q;
      skid_wd_d    = skid_wd_q;
      skid_wreg_d  = skid_wreg_q;
      skid_wdata_d = skid_wdata_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_wd_d    = '0;
         main_wreg_d  = 1'b0;
         main_wdata_d = '0;
         skid_valid_d = 1'b0;
         skid_wd_d    = '0;
         skid_wreg_d  = 1'b0;
         skid_wdata_d = '0;
      end else begin
         case ({main_valid_q, skid_valid_q})
            2'b00: begin
               if (in_fire_s) begin
                  main_valid_d = 1'b1;
                  main_wd_d    = in_wd;
                  main_wreg_d  = in_wreg;
                  main_wdata_d = in_wdata;
               end else begin
                  main_valid_d = 1'b0;
               end
            end
            2'b10: begin
               if (out_fire_s && in_fire_s) begin
                  main_wd_d    = in_wd;
                  main_wreg_d  = in_wreg;
                  main_wdata_d = in_wdata;
               end else if (out_fire_s) begin
                  main_valid_d = 1'b0;
                  main_wd_d    = '0;
                  main_wreg_d  = 1'b0;
                  main_wdata_d = '0;
               end else if (in_fire_s) begin
                  skid_valid_d = 1'b1;
                  skid_wd_d    = in_wd;
                  skid_wreg_d  = in_wreg;
                  skid_wdata_d = in_wdata;
               end else begin
                  main_valid_d = 1'b1;
               end
            end
            2'b11: begin
               if (out_fire_s) begin
                  main_wd_d    = skid_wd_q;
                  main_wreg_d  = skid_wreg_q;
                  main_wdata_d = skid_wdata_q;
                  skid_valid_d = 1'b0;
                  skid_wd_d    = '0;
                  skid_wreg_d  = 1'b0;
                  skid_wdata_d = '0;
               end else begin
                  skid_valid_d = 1'b1;
               end
            end
            default: begin
               main_valid_d = 1'b0;
               main_wd_d    = '0;
               main_wreg_d  = 1'b0;
               main_wdata_d = '0;
               skid_valid_d = 1'b0;
               skid_wd_d    = '0;
               skid_wreg_d  = 1'b0;
               skid_wdata_d = '0;
            end
         endcase
      end
   end

   // Store registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_wd_q    <= '0;
         main_wreg_q  <= 1'b0;
         main_wdata_q <= '0;
         skid_valid_q <= 1'b0;
         skid_wd_q    <= '0;
         skid_wreg_q  <= 1'b0;
         skid_wdata_q <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_wd_q    <= main_wd_d;
         main_wreg_q  <= main_wreg_d;
         main_wdata_q <= main_wdata_d;
         skid_valid_q <= skid_valid_d;
         skid_wd_q    <= skid_wd_d;
         skid_wreg_q  <= skid_wreg_d;
         skid_wdata_q <= skid_wdata_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_wd    = main_valid_q ? main_wd_q    : {ADDR_W{1'b0}};
   assign out_wreg  = main_valid_q ? main_wreg_q  : 1'b0;
   assign out_wdata = main_valid_q ? main_wdata_q : {DATA_W{1'b0}};
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

   // Skid is the younger entry, so it takes precedence on a double match
   assign main_match_s = main_valid_q && main_wreg_q && (main_wd_q == fwd_addr) && (fwd_addr != '0);
   assign skid_match_s = skid_valid_q && skid_wreg_q && (skid_wd_q == fwd_addr) && (fwd_addr != '0);
   assign fwd_hit      = main_match_s || skid_match_s;
   assign fwd_data     = skid_match_s ? skid_wdata_q :
                         main_match_s ? main_wdata_q : {DATA_W{1'b0}};

   ex_mem_elastic_chk u_chk (
      .clk        (clk),
      .rst        (rst),
      .main_valid (main_valid_q),
      .skid_valid (skid_valid_q)
   );

endmodule

// Structural invariant: skid never holds a beat while main is empty.
module ex_mem_elastic_chk (
   input logic clk,
   input logic rst,
   input logic main_valid,
   input logic skid_valid
);
   a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) !(skid_valid && !main_valid));
endmodule

// File: tb/tb_ex_mem_elastic.sv
// Directed bench for ex_mem_elastic: streaming, backpressure, forwarding, flush, reset.
module tb_ex_mem_elastic;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_wreg, out_valid, out_ready, out_wreg, fwd_hit;
   logic [4:0]  in_wd, out_wd, fwd_addr;
   logic [31:0] in_wdata, out_wdata, fwd_data;
   logic [1:0]  occupancy;
   int          total = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   ex_mem_elastic #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .occupancy(occupancy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic [4:0] wd, input logic wr, input logic [31:0] d);
      in_valid = v;
      in_wd    = wd;
      in_wreg  = wr;
      in_wdata = d;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; fwd_addr = 5'd0;
      beat(1'b0, 5'd0, 1'b0, 32'h0);
      step(); step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_wd", 64'(out_wd), 64'd0);
      chk("rst_out_wreg", 64'(out_wreg), 64'd0);
      chk("rst_out_wdata", 64'(out_wdata), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
      chk("rst_fwd_data", 64'(fwd_data), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // streaming with out_ready=1
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, 5'(i + 1), 1'b1, 32'h10 + 32'(i));
         #1;
         chk("stream_in_ready", 64'(in_ready), 64'd1);
         step();
         chk("stream_out_valid", 64'(out_valid), 64'd1);
         chk("stream_out_wd", 64'(out_wd), 64'(i + 1));
         chk("stream_out_wdata", 64'(out_wdata), 64'h10 + 64'(i));
         chk("stream_occ", 64'(occupancy), 64'd1);
      end
      beat(1'b0, 5'd0, 1'b0, 32'h0);
      step();
      chk("stream_drain_valid", 64'(out_valid), 64'd0);
      chk("stream_drain_occ", 64'(occupancy), 64'd0);

      // backpressure: A, B fill the store, C waits at the input
      out_ready = 1'b0;
      beat(1'b1, 5'd5, 1'b1, 32'hAA);
      step();
      chk("bp_a_occ", 64'(occupancy), 64'd1);
      chk("bp_a_in_ready", 64'(in_ready), 64'd1);
      beat(1'b1, 5'd6, 1'b1, 32'hBB);
      step();
      chk("bp_b_occ", 64'(occupancy), 64'd2);
      chk("bp_b_in_ready", 64'(in_ready), 64'd0);
      chk("bp_b_out_wd", 64'(out_wd), 64'd5);
      beat(1'b1, 5'd8, 1'b1, 32'hCC);
      step();
      chk("bp_hold_occ", 64'(occupancy), 64'd2);
      chk("bp_hold_wdata", 64'(out_wdata), 64'hAA);
      chk("bp_hold_wd", 64'(out_wd), 64'd5);
      out_ready = 1'b1;
      step();
      chk("bp_out_b", 64'(out_wdata), 64'hBB);
      chk("bp_out_b_occ", 64'(occupancy), 64'd1);
      chk("bp_in_ready_back", 64'(in_ready), 64'd1);
      step();
      chk("bp_out_c", 64'(out_wdata), 64'hCC);
      chk("bp_out_c_wd", 64'(out_wd), 64'd8);
      beat(1'b0, 5'd0, 1'b0, 32'h0);
      step();
      chk("bp_empty", 64'(occupancy), 64'd0);

      // forwarding with two matching entries: skid (younger) wins
      out_ready = 1'b0;
      beat(1'b1, 5'd7, 1'b1, 32'h11);
      step();
      beat(1'b1, 5'd7, 1'b1, 32'h22);
      step();
      beat(1'b0, 5'd0, 1'b0, 32'h0);
      fwd_addr = 5'd7;
      #1;
      chk("fwd_hit_7", 64'(fwd_hit), 64'd1);
      chk("fwd_data_7", 64'(fwd_data), 64'h22);
      fwd_addr = 5'd5;
      #1;
      chk("fwd_miss_hit", 64'(fwd_hit), 64'd0);
      chk("fwd_miss_data", 64'(fwd_data), 64'd0);
      fwd_addr = 5'd0;
      #1;
      chk("fwd_x0_hit", 64'(fwd_hit), 64'd0);

      // flush with a full store and a presented beat
      beat(1'b1, 5'd9, 1'b1, 32'h99);
      flush = 1'b1;
      step();
      flush = 1'b0;
      beat(1'b0, 5'd0, 1'b0, 32'h0);
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_wd", 64'(out_wd), 64'd0);
      chk("flush_wreg", 64'(out_wreg), 64'd0);
      chk("flush_wdata", 64'(out_wdata), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      step();
      chk("flush_no_ghost", 64'(out_valid), 64'd0);

      // wreg=0 entries are carried but never forward
      out_ready = 1'b0;
      beat(1'b1, 5'd3, 1'b0, 32'h33);
      step();
      beat(1'b1, 5'd3, 1'b0, 32'h44);
      step();
      beat(1'b0, 5'd0, 1'b0, 32'h0);
      fwd_addr = 5'd3;
      #1;
      chk("fwd_nowreg_hit", 64'(fwd_hit), 64'd0);
      chk("fwd_nowreg_data", 64'(fwd_data), 64'd0);
      chk("nowreg_out_wreg", 64'(out_wreg), 64'd0);
      chk("nowreg_out_wdata", 64'(out_wdata), 64'h33);
      flush = 1'b1;
      step();
      flush = 1'b0;

      // beat right after a flush is accepted, then 10 cycles of simultaneous fire
      out_ready = 1'b1;
      beat(1'b1, 5'd10, 1'b1, 32'hA0);
      step();
      chk("post_flush_valid", 64'(out_valid), 64'd1);
      chk("post_flush_wd", 64'(out_wd), 64'd10);
      for (int i = 0; i < 10; i++) begin
         beat(1'b1, 5'(i + 11), 1'b1, 32'h100 + 32'(i));
         step();
         fwd_addr = 5'(i + 11);
         #1;
         chk("thru_wdata", 64'(out_wdata), 64'h100 + 64'(i));
         chk("thru_wd", 64'(out_wd), 64'(i + 11));
         chk("thru_occ", 64'(occupancy), 64'd1);
         chk("thru_fwd_data", 64'(fwd_data), 64'h100 + 64'(i));
      end

      // reset mid-stream with a full store
      out_ready = 1'b0;
      beat(1'b1, 5'd30, 1'b1, 32'hEE);
      step();
      chk("pre_rst_occ", 64'(occupancy), 64'd2);
      rst = 1'b1;
      fwd_addr = 5'd30;
      step();
      chk("mid_rst_occ", 64'(occupancy), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_wdata", 64'(out_wdata), 64'd0);
      chk("mid_rst_fwd_hit", 64'(fwd_hit), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      beat(1'b0, 5'd0, 1'b0, 32'h0);
      step();
      chk("after_rst_in_ready", 64'(in_ready), 64'd1);
      chk("after_rst_occ", 64'(occupancy), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
